// File: rtl/comparator_serial.sv
// Bit-serial MSB-first magnitude comparator: captures two operands on start,
// resolves at the first differing bit and reports registered relational flags.
module comparator_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             signed_mode,
    input  logic [WIDTH-1:0]                 valA,
    input  logic [WIDTH-1:0]                 valB,
    output logic                             busy,
    output logic                             done,
    output logic                             aGTb,
    output logic                             aGEb,
    output logic                             aLTb,
    output logic                             aLEb,
    output logic                             aEQb,
    output logic                             aNEb,
    output logic [$clog2(WIDTH+1)-1:0]       bits_examined
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    // Flag order: {gt, ge, lt, le, eq, ne}
    logic [5:0]       flags_q, flags_d;

    logic             bit_a;
    logic             bit_b;
    logic             sign_pos;
    logic             a_wins;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        flags_d  = flags_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        bit_a    = opa_q[idx_q];
        bit_b    = opb_q[idx_q];
        sign_pos = (idx_q == IW'(WIDTH - 1));
        // In signed mode a set sign bit means the smaller value.
        a_wins   = bit_a ^ (sgn_q & sign_pos);

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = valA;
                    opb_d   = valB;
                    sgn_d   = signed_mode;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (bit_a != bit_b) begin
                    flags_d = a_wins ? 6'b110001 : 6'b001101;
                    bits_d  = cnt_q + CW'(1);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    flags_d = 6'b010110;
                    bits_d  = cnt_q + CW'(1);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign aGTb          = flags_q[5];
    assign aGEb          = flags_q[4];
    assign aLTb          = flags_q[3];
    assign aLEb          = flags_q[2];
    assign aEQb          = flags_q[1];
    assign aNEb          = flags_q[0];
    assign bits_examined = bits_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial at WIDTH 8, 2 and 32 against an
// arithmetic reference model.
module tb_comparator_serial;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        st [3];
    logic        sm [3];
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        bz [3];
    logic        dn [3];
    logic [5:0]  fl [3];
    logic [5:0]  be [3];
    logic [3:0]  be8;
    logic [1:0]  be2;
    logic [5:0]  be32;
    int          wid [3] = '{8, 2, 32};
    int          vectors = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign be[0] = 6'(be8);
    assign be[1] = 6'(be2);
    assign be[2] = be32;

    comparator_serial #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .signed_mode(sm[0]),
        .valA(va[0][7:0]), .valB(vb[0][7:0]), .busy(bz[0]), .done(dn[0]),
        .aGTb(fl[0][5]), .aGEb(fl[0][4]), .aLTb(fl[0][3]), .aLEb(fl[0][2]),
        .aEQb(fl[0][1]), .aNEb(fl[0][0]), .bits_examined(be8));

    comparator_serial #(.WIDTH(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .signed_mode(sm[1]),
        .valA(va[1][1:0]), .valB(vb[1][1:0]), .busy(bz[1]), .done(dn[1]),
        .aGTb(fl[1][5]), .aGEb(fl[1][4]), .aLTb(fl[1][3]), .aLEb(fl[1][2]),
        .aEQb(fl[1][1]), .aNEb(fl[1][0]), .bits_examined(be2));

    comparator_serial #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset_n(reset_n), .start(st[2]), .signed_mode(sm[2]),
        .valA(va[2]), .valB(vb[2]), .busy(bz[2]), .done(dn[2]),
        .aGTb(fl[2][5]), .aGEb(fl[2][4]), .aLTb(fl[2][3]), .aLEb(fl[2][2]),
        .aEQb(fl[2][1]), .aNEb(fl[2][0]), .bits_examined(be32));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: compare as integers; k = leading equal bits + 1, capped at w.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit s, output logic [5:0] f, output int k);
        longint      av;
        longint      bv;
        logic [31:0] x;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        f = {av > bv, av >= bv, av < bv, av <= bv, av == bv, av != bv};
        x = a ^ b;
        k = w;
        for (int i = 0; i < w; i++)
            if (x[i]) k = w - i;
    endfunction

    task automatic launch(input int sel, input logic [31:0] a, input logic [31:0] b, input bit s);
        va[sel] = a;
        vb[sel] = b;
        sm[sel] = s;
        st[sel] = 1'b1;
    endtask

    // Waits for done, counting busy cycles; optionally keeps start high and
    // disturbs the operand inputs mid-scan.
    task automatic collect(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input bit hold, input bit chg);
        logic [5:0] ef;
        int         ek;
        int         nb = 0;
        bit         seen = 0;
        bit         busy_at_done = 0;
        model(wid[sel], a, b, s, ef, ek);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (dn[sel]) begin
                seen = 1;
                busy_at_done = bz[sel];
            end else if (bz[sel]) begin
                nb++;
            end
            if (!hold) st[sel] = 1'b0;
            if (chg && nb == 2) va[sel] = 32'hFF;
            if (chg && nb == 4) begin
                va[sel] = 32'h01;
                vb[sel] = 32'h00;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("flags", 32'(fl[sel]), 32'(ef));
        chk("bits_examined", 32'(be[sel]), 32'(ek));
        chk("busy_cycles", 32'(nb), 32'(ek));
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        if (!hold) begin
            @(negedge clk);
            chk("done_pulse_width", 32'(dn[sel]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] mask;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          glitch;

        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            sm[i] = 1'b0;
            va[i] = '0;
            vb[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", 32'(bz[i]), 32'd0);
            chk("reset_done", 32'(dn[i]), 32'd0);
            chk("reset_flags", 32'(fl[i]), 32'd0);
            chk("reset_bits", 32'(be[i]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Directed WIDTH=8 cases
        launch(0, 32'h80, 32'h7F, 1'b0); collect(0, 32'h80, 32'h7F, 1'b0, 1'b0, 1'b0);
        chk("u_80_7f_gt", 32'(fl[0]), 32'b110001);
        launch(0, 32'h80, 32'h7F, 1'b1); collect(0, 32'h80, 32'h7F, 1'b1, 1'b0, 1'b0);
        chk("s_80_7f_lt", 32'(fl[0]), 32'b001101);
        launch(0, 32'h5A, 32'h5A, 1'b0); collect(0, 32'h5A, 32'h5A, 1'b0, 1'b0, 1'b0);
        launch(0, 32'h5A, 32'h5A, 1'b1); collect(0, 32'h5A, 32'h5A, 1'b1, 1'b0, 1'b0);
        chk("eq_bits8", 32'(be[0]), 32'd8);

        // LSB difference with start held, operands disturbed, back-to-back op
        launch(0, 32'h12, 32'h13, 1'b0); collect(0, 32'h12, 32'h13, 1'b0, 1'b1, 1'b1);
        chk("lsb_lt", 32'(fl[0]), 32'b001101);
        collect(0, 32'h01, 32'h00, 1'b0, 1'b0, 1'b0);
        chk("b2b_gt", 32'(fl[0]), 32'b110001);

        // Width extremes
        launch(1, 32'h3, 32'h1, 1'b1); collect(1, 32'h3, 32'h1, 1'b1, 1'b0, 1'b0);
        chk("w2_lt", 32'(fl[1]), 32'b001101);
        launch(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        collect(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        chk("w32_bits", 32'(be[2]), 32'd32);

        // Random operands with a varied first-difference position
        for (int sel = 0; sel < 3; sel++) begin
            mask = (wid[sel] == 32) ? 32'hFFFFFFFF : ((32'd1 << wid[sel]) - 32'd1);
            for (int n = 0; n < 15; n++) begin
                ra = $urandom & mask;
                rb = (ra ^ ($urandom >> $urandom_range(0, 31))) & mask;
                rs = 1'($urandom_range(0, 1));
                launch(sel, ra, rb, rs);
                collect(sel, ra, rb, rs, 1'b0, 1'b0);
            end
        end

        // Reset asserted mid-scan aborts without a done pulse
        launch(0, 32'h00, 32'h00, 1'b0);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", 32'(bz[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        chk("abort_flags", 32'(fl[0]), 32'd0);
        chk("abort_bits", 32'(be[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        glitch = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bz[0] || dn[0]) glitch++;
        end
        chk("post_abort_quiet", 32'(glitch), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
